data_stack: RTL and testbench
=============================

// Module: data_stack
// PURPOSE
//   LIFO data stack consuming data_sp_push / data_sp_pop from the instruction decoder.
//   PUSH writes the accumulator value; POP, SADD and SMLT read and pop the top entry.
//   Sits beside the ALU: the accumulator drives din, and dout feeds the ALU operand mux.
//   Top-of-stack is held in a register so the ALU sees it with no read latency.
// PARAMETERS
//   DATA_WIDTH  32  entry width; equals the accumulator width
//   DEPTH_LOG2  4   log2 of entry count; DEPTH = 2**DEPTH_LOG2 = 16 entries
// PORTS
//   clk      in   1             system clock, rising edge
//   rst_n    in   1             synchronous reset, active-low
//   push     in   1             from decoder data_sp_push
//   pop      in   1             from decoder data_sp_pop
//   din      in   DATA_WIDTH    value to push (signed accumulator)
//   dout     out  DATA_WIDTH    current top of stack (registered)
//   count    out  DEPTH_LOG2+1  number of valid entries, 0..DEPTH
//   empty    out  1             count == 0
//   full     out  1             count == DEPTH
//   err_ovf  out  1             sticky overflow flag (see CONFIGURATION)
//   err_unf  out  1             sticky underflow flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): count=0, dout=0, err_ovf=0, err_unf=0. Storage is not cleared.
//   All state updates on the rising clk edge; empty and full decode combinationally from count.
//   Latency: dout, count and the flags reflect an operation on the edge that samples it.
//     During the pop cycle, dout still shows the entry being popped (SADD/SMLT consume it there).
//   push & !pop, !full:  mem[count] <= din; dout <= din; count += 1.
//   pop & !push, !empty: count -= 1; dout <= (count >= 2) ? mem[count-2] : 0.
//   push & pop, !empty:  replace top. mem[count-1] <= din; dout <= din; count unchanged.
//   push & pop, empty:   treated as push-only. No underflow is raised.
//   push & !pop, full:   ignored; count, dout and storage are unchanged; overflow event.
//   pop & !push, empty:  ignored; dout stays 0; underflow event.
//   Idle (!push & !pop): hold all state.
//   count never wraps; it saturates at 0 and DEPTH by the rules above.
//   Reset mid-operation: reset wins, and any concurrent push or pop is discarded.
//   Data is opaque: no sign extension or arithmetic is performed.
// CONFIGURATION
//   DATA_STACK_ERR_EN defined:
//     err_ovf / err_unf set on the corresponding event and stay set until reset.
//   DATA_STACK_ERR_EN undefined:
//     err_ovf / err_unf are tied to 0 and no flag registers are built.
//   Illegal operations are ignored in both builds.
// STRUCTURE
//   Shared package sc_pkg holds:
//     DATA_WIDTH default, opcode constants (NOP..SMLT, 4-bit), ALU op constants (3-bit).
//   One sub-module, stack_ram:
//     DEPTH x DATA_WIDTH, one synchronous write port, one asynchronous read port
//     (address count-2 for the pop refill).
//   The pointer/count logic, top register and error flags stay in data_stack.
// TESTING
//   1 Reset, then push 5, 7, -3 on consecutive cycles
//     -> dout 5, 7, -3 after each edge; count=3; empty=0.
//   2 From test 1, pop x3
//     -> dout 7, 5, 0; count 2, 1, 0; empty=1 after the third pop.
//   3 Push 1..16 -> full=1, count=16. Push 99
//     -> dout=16, count=16, err_ovf=1 (0 when DATA_STACK_ERR_EN is undefined).
//   4 From empty, pop -> count=0, dout=0, err_unf=1. Then push&pop with din=4
//     -> count=1, dout=4, err_unf still 1.
//   5 Stack [10,20], push&pop with din=30 -> count=2, dout=30. Pop -> dout=10.
//   6 Push 8, then assert rst_n=0 in the same cycle as push 9
//     -> count=0, dout=0, flags 0. Next push 2 -> dout=2, count=1.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared stack-computer package: default widths, decoder opcodes, ALU op
// codes and the data-stack operation decode used by data_stack.
package sc_pkg;

    localparam int SC_DATA_WIDTH = 32;
    localparam int SC_DEPTH_LOG2 = 4;

    // Instruction opcodes seen by the decoder.
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_PUSH = 4'd2,
        OP_POP  = 4'd3,
        OP_SADD = 4'd4,
        OP_SMLT = 4'd5
    } opcode_e;

    // ALU operation select.
    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_LOAD = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_MUL  = 3'd3
    } alu_op_e;

    // Effective stack operation after legality checks.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP,
        ST_REPLACE,
        ST_OVF,
        ST_UNF
    } stack_op_e;

    // Push & pop on an empty stack is a plain push; illegal requests map to
    // the OVF/UNF events so the caller only has to act on legal ones.
    function automatic stack_op_e decode_stack_op(input logic push, input logic pop,
                                                  input logic empty, input logic full);
        if (push && pop) return empty ? ST_PUSH : ST_REPLACE;
        if (push)        return full  ? ST_OVF  : ST_PUSH;
        if (pop)         return empty ? ST_UNF  : ST_POP;
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/data_stack_if.sv
// Decoder <-> data stack interface. The decoder side is the master.
interface data_stack_if
    import sc_pkg::*;
#(
    parameter int DATA_WIDTH = SC_DATA_WIDTH,
    parameter int DEPTH_LOG2 = SC_DEPTH_LOG2
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic [DEPTH_LOG2:0]   count;
    logic                  empty;
    logic                  full;
    logic                  err_ovf;
    logic                  err_unf;

    modport master (
        output push, pop, din,
        input  dout, count, empty, full, err_ovf, err_unf
    );

    modport slave (
        input  push, pop, din,
        output dout, count, empty, full, err_ovf, err_unf
    );
endinterface

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
module stack_ram
    import sc_pkg::*;
#(
    parameter int DATA_WIDTH = SC_DATA_WIDTH,
    parameter int ADDR_WIDTH = SC_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    // Write the addressed entry on the clock edge.
    // NOTE: storage has no reset; only valid entries (below count) are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/data_stack.sv
// LIFO data stack beside the ALU. Top-of-stack is kept in dout_q so the ALU
// operand mux sees it with no read latency; the RAM holds every entry and is
// read asynchronously at count-2 to refill the top register on a pop.
// Optional feature: define DATA_STACK_ERR_EN to build sticky err_ovf/err_unf.
module data_stack
    import sc_pkg::*;
#(
    parameter int DATA_WIDTH = SC_DATA_WIDTH,
    parameter int DEPTH_LOG2 = SC_DEPTH_LOG2
) (
    input  logic         clk,
    input  logic         rst_n,
    data_stack_if.slave  bus
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] CNT_TWO  = (DEPTH_LOG2+1)'(2);
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [DEPTH_LOG2:0]   count_q, count_d, count_m1, count_m2;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, rd_data;
    logic [DEPTH_LOG2-1:0] wr_addr, rd_addr;
    logic                  wr_en, empty, full;
    stack_op_e             op;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign count_m1 = count_q - CNT_ONE;
    assign count_m2 = count_q - CNT_TWO;
    assign rd_addr  = count_m2[DEPTH_LOG2-1:0];
    assign op       = decode_stack_op(bus.push, bus.pop, empty, full);

    // Next count, next top-of-stack and RAM write for the decoded operation.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        wr_en   = 1'b0;
        wr_addr = count_q[DEPTH_LOG2-1:0];
        case (op)
            ST_PUSH: begin
                wr_en   = 1'b1;
                dout_d  = bus.din;
                count_d = count_q + CNT_ONE;
            end
            ST_REPLACE: begin
                wr_en   = 1'b1;
                wr_addr = count_m1[DEPTH_LOG2-1:0];
                dout_d  = bus.din;
            end
            ST_POP: begin
                count_d = count_m1;
                dout_d  = (count_q >= CNT_TWO) ? rd_data : '0;
            end
            default: ;
        endcase
    end

    stack_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en && rst_n),   // a push concurrent with reset is discarded
        .wr_addr (wr_addr),
        .wr_data (bus.din),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Count and top-of-stack registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

`ifdef DATA_STACK_ERR_EN
    logic err_ovf_q, err_unf_q;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_q | (op == ST_OVF);
            err_unf_q <= err_unf_q | (op == ST_UNF);
        end
    end

    assign bus.err_ovf = err_ovf_q;
    assign bus.err_unf = err_unf_q;
`else
    assign bus.err_ovf = 1'b0;
    assign bus.err_unf = 1'b0;
`endif

    assign bus.dout  = dout_q;
    assign bus.count = count_q;
    assign bus.empty = empty;
    assign bus.full  = full;
endmodule

// File: tb/tb_data_stack.sv
// Directed testbench for data_stack. Expected error-flag values follow
// whether DATA_STACK_ERR_EN is defined for the build.
module tb_data_stack;
    import sc_pkg::*;

    localparam int DW = 32;
    localparam int DL = 4;
`ifdef DATA_STACK_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    data_stack_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    data_stack #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs and advance to just after the rising edge.
    task automatic cycle(input logic push, input logic pop, input logic [DW-1:0] din);
        bus.push = push;
        bus.pop  = pop;
        bus.din  = din;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        tests++; if (bus.dout !== 32'd0) begin fails++; $display("FAIL rst_dout got=%h exp=0", bus.dout); end
        tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin fails++; $display("FAIL rst_empty_full got=%b%b exp=10", bus.empty, bus.full); end
        tests++; if (bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0) begin fails++; $display("FAIL rst_flags got=%b%b exp=00", bus.err_ovf, bus.err_unf); end
        rst_n = 1'b1;
    endtask

    task automatic test_push_seq();
        logic [DW-1:0] vals [3];
        vals[0] = 32'd5; vals[1] = 32'd7; vals[2] = 32'hFFFF_FFFD;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, vals[i]);
            tests++; if (bus.dout !== vals[i]) begin fails++; $display("FAIL push_dout[%0d] got=%h exp=%h", i, bus.dout, vals[i]); end
            tests++; if (bus.count !== 5'(i + 1)) begin fails++; $display("FAIL push_count[%0d] got=%0d exp=%0d", i, bus.count, i + 1); end
        end
        tests++; if (bus.empty !== 1'b0) begin fails++; $display("FAIL push_empty got=%b exp=0", bus.empty); end
    endtask

    task automatic test_pop_seq();
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 32'd7; exp_d[1] = 32'd5; exp_d[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, '0);
            tests++; if (bus.dout !== exp_d[i]) begin fails++; $display("FAIL pop_dout[%0d] got=%h exp=%h", i, bus.dout, exp_d[i]); end
            tests++; if (bus.count !== 5'(2 - i)) begin fails++; $display("FAIL pop_count[%0d] got=%0d exp=%0d", i, bus.count, 2 - i); end
        end
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL pop_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_full_ovf();
        for (int i = 1; i <= 16; i++) begin
            tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL fill_early_full[%0d] got=%b exp=0", i, bus.full); end
            cycle(1'b1, 1'b0, 32'(i));
        end
        tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL full_flag got=%b exp=1", bus.full); end
        tests++; if (bus.count !== 5'd16) begin fails++; $display("FAIL full_count got=%0d exp=16", bus.count); end
        cycle(1'b1, 1'b0, 32'd99);
        tests++; if (bus.dout !== 32'd16) begin fails++; $display("FAIL ovf_dout got=%0d exp=16", bus.dout); end
        tests++; if (bus.count !== 5'd16) begin fails++; $display("FAIL ovf_count got=%0d exp=16", bus.count); end
        tests++; if (bus.err_ovf !== EXP_ERR) begin fails++; $display("FAIL ovf_flag got=%b exp=%b", bus.err_ovf, EXP_ERR); end
        tests++; if (bus.err_unf !== 1'b0) begin fails++; $display("FAIL ovf_unf got=%b exp=0", bus.err_unf); end
    endtask

    // Drain the full stack; the top must walk 15, 14, ... 1, then 0.
    task automatic test_drain();
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 1'b1, '0);
            tests++; if (bus.dout !== 32'(16 - k) || bus.count !== 5'(16 - k)) begin
                fails++; $display("FAIL drain[%0d] got dout=%0d count=%0d exp=%0d", k, bus.dout, bus.count, 16 - k);
            end
        end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b1, 32'd55);
        tests++; if (bus.count !== 5'd0 || bus.dout !== 32'd0) begin fails++; $display("FAIL unf_state got count=%0d dout=%0d exp=0/0", bus.count, bus.dout); end
        tests++; if (bus.err_unf !== EXP_ERR) begin fails++; $display("FAIL unf_flag got=%b exp=%b", bus.err_unf, EXP_ERR); end
        tests++; if (bus.err_ovf !== EXP_ERR) begin fails++; $display("FAIL unf_ovf_sticky got=%b exp=%b", bus.err_ovf, EXP_ERR); end
        cycle(1'b1, 1'b1, 32'd4);
        tests++; if (bus.count !== 5'd1 || bus.dout !== 32'd4) begin fails++; $display("FAIL pp_empty got count=%0d dout=%0d exp=1/4", bus.count, bus.dout); end
        tests++; if (bus.err_unf !== EXP_ERR) begin fails++; $display("FAIL pp_empty_unf got=%b exp=%b", bus.err_unf, EXP_ERR); end
    endtask

    task automatic test_replace();
        cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 32'd10);
        cycle(1'b1, 1'b0, 32'd20);
        cycle(1'b1, 1'b1, 32'd30);
        tests++; if (bus.count !== 5'd2 || bus.dout !== 32'd30) begin fails++; $display("FAIL replace got count=%0d dout=%0d exp=2/30", bus.count, bus.dout); end
        cycle(1'b0, 1'b0, 32'd77);
        cycle(1'b0, 1'b0, 32'd78);
        tests++; if (bus.count !== 5'd2 || bus.dout !== 32'd30) begin fails++; $display("FAIL idle_hold got count=%0d dout=%0d exp=2/30", bus.count, bus.dout); end
        cycle(1'b0, 1'b1, '0);
        tests++; if (bus.count !== 5'd1 || bus.dout !== 32'd10) begin fails++; $display("FAIL replace_pop got count=%0d dout=%0d exp=1/10", bus.count, bus.dout); end
    endtask

    task automatic test_reset_mid_op();
        cycle(1'b1, 1'b0, 32'd8);
        tests++; if (bus.dout !== 32'd8 || bus.count !== 5'd2) begin fails++; $display("FAIL pre_rst got count=%0d dout=%0d exp=2/8", bus.count, bus.dout); end
        rst_n = 1'b0;
        cycle(1'b1, 1'b0, 32'd9);
        rst_n = 1'b1;
        tests++; if (bus.count !== 5'd0 || bus.dout !== 32'd0) begin fails++; $display("FAIL mid_rst got count=%0d dout=%0d exp=0/0", bus.count, bus.dout); end
        tests++; if (bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0) begin fails++; $display("FAIL mid_rst_flags got=%b%b exp=00", bus.err_ovf, bus.err_unf); end
        cycle(1'b1, 1'b0, 32'd2);
        tests++; if (bus.count !== 5'd1 || bus.dout !== 32'd2) begin fails++; $display("FAIL post_rst got count=%0d dout=%0d exp=1/2", bus.count, bus.dout); end
        cycle(1'b1, 1'b0, 32'd3);
        cycle(1'b0, 1'b1, '0);
        tests++; if (bus.count !== 5'd1 || bus.dout !== 32'd2) begin fails++; $display("FAIL post_rst_pop got count=%0d dout=%0d exp=1/2", bus.count, bus.dout); end
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.din  = '0;
        test_reset();
        test_push_seq();
        test_pop_seq();
        test_full_ovf();
        test_drain();
        test_underflow();
        test_replace();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
